// File: rtl/alu_pkg.sv
// Shared opcode and status-flag definitions for the registered ALU.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_NOT = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } alu_op_e;

  typedef struct packed {
    logic zero;
    logic neg;
    logic carry;
    logic ovf;
  } alu_flags_t;

  // Flag state while in reset: result is 0, so only zero is set.
  localparam alu_flags_t FLAGS_RST = '{zero: 1'b1, neg: 1'b0, carry: 1'b0, ovf: 1'b0};

endpackage

// File: rtl/alu_core.sv
// Combinational op decode, result and flag generation for the ALU.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] r,
  output alu_flags_t       flags
);

  localparam int MSB = WIDTH - 1;

  logic        [WIDTH:0]   sum;
  logic        [WIDTH:0]   diff;
  logic signed [WIDTH-1:0] a_s;
  logic signed [WIDTH-1:0] b_s;
  logic signed [WIDTH-1:0] r_s;

  assign sum  = {1'b0, a} + {1'b0, b};
  // The extra top bit of the zero-extended difference is the borrow.
  assign diff = {1'b0, a} - {1'b0, b};
  assign a_s  = a;
  assign b_s  = b;
  assign r_s  = r;

  always_comb begin
    r           = sum[MSB:0];
    flags.carry = 1'b0;
    flags.ovf   = 1'b0;
    case (op)
      OP_ADD: begin
        r           = sum[MSB:0];
        flags.carry = sum[WIDTH];
        flags.ovf   = (a_s[MSB] == b_s[MSB]) && (r_s[MSB] != a_s[MSB]);
      end
      OP_SUB: begin
        r           = diff[MSB:0];
        flags.carry = diff[WIDTH];
        flags.ovf   = (a_s[MSB] != b_s[MSB]) && (r_s[MSB] != a_s[MSB]);
      end
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      OP_XOR: r = a ^ b;
      OP_NOT: r = ~a;
      OP_SHL: begin
        r           = {a[MSB-1:0], 1'b0};
        flags.carry = a[MSB];
      end
      OP_SHR: begin
        r           = {1'b0, a[MSB:1]};
        flags.carry = a[0];
      end
      // Undefined opcode behaves as ADD so state is never corrupted.
      default: begin
        r           = sum[MSB:0];
        flags.carry = sum[WIDTH];
        flags.ovf   = (a_s[MSB] == b_s[MSB]) && (r_s[MSB] != a_s[MSB]);
      end
    endcase
    flags.zero = (r == '0);
    flags.neg  = r[MSB];
  end

endmodule

// File: rtl/alu.sv
// Registered ALU: one-cycle latency, one operation per clock, held result when idle.
module alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_op,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out_r,
  output logic             out_valid,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf
);

  logic [WIDTH-1:0] r_p0;
  alu_flags_t       flags_p0;
  logic [WIDTH-1:0] r_p1;
  alu_flags_t       flags_p1;
  logic             vld_p1;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .a     (in_a),
    .b     (in_b),
    .op    (in_op),
    .r     (r_p0),
    .flags (flags_p0)
  );

  // p0 -> p1: output register stage
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_p1     <= '0;
      flags_p1 <= FLAGS_RST;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= in_valid;
      if (in_valid) begin
        r_p1     <= r_p0;
        flags_p1 <= flags_p0;
      end
    end
  end

  assign out_r     = r_p1;
  assign out_valid = vld_p1;
  assign out_zero  = flags_p1.zero;
  assign out_neg   = flags_p1.neg;
  assign out_carry = flags_p1.carry;
  assign out_ovf   = flags_p1.ovf;

endmodule

// File: tb/tb_alu.sv
// Directed self-checking bench for the registered ALU.
module tb_alu;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] in_a, in_b;
  logic [2:0] in_op;
  logic       in_valid;
  logic [7:0] out_r;
  logic       out_valid, out_zero, out_neg, out_carry, out_ovf;

  int tests = 0;
  int fails = 0;

  // Observed packed as {r, valid, zero, neg, carry, ovf}.
  logic [12:0] obs;

  alu #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_valid  (in_valid),
    .out_r     (out_r),
    .out_valid (out_valid),
    .out_zero  (out_zero),
    .out_neg   (out_neg),
    .out_carry (out_carry),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;

  assign obs = {out_r, out_valid, out_zero, out_neg, out_carry, out_ovf};

  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_valid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_a = '0; in_b = '0; in_op = '0; in_valid = 1'b0;
    #12;
    tests++;
    if (obs !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_state got %h required %h", obs, {8'h00, 5'b01000});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_arith();
    issue(8'h79, 8'h65, 3'd0);
    tests++;
    if (obs !== {8'hDE, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1}) begin
      fails++; $display("FAIL add got %h required %h", obs, {8'hDE, 5'b10101});
    end
    issue(8'h79, 8'h65, 3'd1);
    tests++;
    if (obs !== {8'h14, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL sub got %h required %h", obs, {8'h14, 5'b10000});
    end
    issue(8'h65, 8'h79, 3'd1);
    tests++;
    if (obs !== {8'hEC, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}) begin
      fails++; $display("FAIL sub_borrow got %h required %h", obs, {8'hEC, 5'b10110});
    end
  endtask

  task automatic test_logic();
    logic [7:0] exp_r [4];
    exp_r = '{8'h61, 8'h7D, 8'h1C, 8'h86};
    for (int i = 0; i < 4; i++) begin
      issue(8'h79, 8'h65, 3'(i + 2));
      tests++;
      if (obs !== {exp_r[i], 1'b1, 1'b0, exp_r[i][7], 1'b0, 1'b0}) begin
        fails++; $display("FAIL logic_op%0d got %h required %h", i + 2, obs, {exp_r[i], 1'b1, 1'b0, exp_r[i][7], 2'b00});
      end
    end
  endtask

  task automatic test_shift();
    issue(8'h79, 8'h65, 3'd6);
    tests++;
    if (obs !== {8'hF2, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
      fails++; $display("FAIL shl got %h required %h", obs, {8'hF2, 5'b10100});
    end
    issue(8'h79, 8'h65, 3'd7);
    tests++;
    if (obs !== {8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL shr got %h required %h", obs, {8'h3C, 5'b10010});
    end
  endtask

  task automatic test_edges();
    issue(8'hFF, 8'h01, 3'd0);
    tests++;
    if (obs !== {8'h00, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0}) begin
      fails++; $display("FAIL add_wrap got %h required %h", obs, {8'h00, 5'b11010});
    end
    issue(8'h80, 8'h01, 3'd1);
    tests++;
    if (obs !== {8'h7F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL sub_ovf got %h required %h", obs, {8'h7F, 5'b10001});
    end
  endtask

  task automatic test_hold();
    issue(8'h79, 8'h65, 3'd4);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_a = 8'hFF; in_b = 8'hFF; in_op = 3'd0; in_valid = 1'b0;
      @(posedge clk);
      #1;
      tests++;
      if (obs !== {8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
        fails++; $display("FAIL hold_%0d got %h required %h", i, obs, {8'h1C, 5'b00000});
      end
    end
  endtask

  task automatic test_async_reset();
    issue(8'h79, 8'h65, 3'd0);
    @(negedge clk);
    in_a = 8'h79; in_b = 8'h65; in_op = 3'd6; in_valid = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    tests++;
    if (obs !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL async_reset got %h required %h", obs, {8'h00, 5'b01000});
    end
    @(posedge clk);
    #1;
    tests++;
    if (obs !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      fails++; $display("FAIL reset_hold got %h required %h", obs, {8'h00, 5'b01000});
    end
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    logic [7:0] exp_r [8];
    logic [7:0] exp_c;
    logic [7:0] exp_v;
    exp_r = '{8'hDE, 8'h14, 8'h61, 8'h7D, 8'h1C, 8'h86, 8'hF2, 8'h3C};
    exp_c = 8'b1000_0000;
    exp_v = 8'b0000_0001;
    for (int i = 0; i < 8; i++) begin
      issue(8'h79, 8'h65, 3'(i));
      tests++;
      if (obs !== {exp_r[i], 1'b1, 1'b0, exp_r[i][7], exp_c[i], exp_v[i]}) begin
        fails++; $display("FAIL b2b_op%0d got %h required %h", i, obs, {exp_r[i], 1'b1, 1'b0, exp_r[i][7], exp_c[i], exp_v[i]});
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_arith();
    test_logic();
    test_shift();
    test_edges();
    test_hold();
    test_async_reset();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu.md
# alu

- Registered 8-bit arithmetic/logic unit for the convolution datapath.
- Each cycle it takes two operands and a 3-bit opcode, and registers an 8-bit result plus status flags.
- The result is available one clock later.
- Sits between the operand register file and the accumulator/writeback stage.

## Interface
- `WIDTH`, default 8: operand and result width; all rules below hold for any WIDTH ≥ 2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_a` input WIDTH: operand A.
- `in_b` input WIDTH: operand B.
- `in_op` input 3: opcode.
- `in_valid` input 1: operands/opcode valid this cycle.
- `out_r` output WIDTH: registered result.
- `out_valid` output 1: `out_r` and flags hold a new result.
- `out_zero` output 1: `out_r == 0`.
- `out_neg` output 1: MSB of `out_r`.
- `out_carry` output 1: carry/borrow/shifted-out bit.
- `out_ovf` output 1: signed (two's-complement) overflow.

## Operation
Opcodes (unsigned WIDTH-bit arithmetic, result truncated to WIDTH):
- 0 ADD: r = a + b. carry = bit WIDTH of the full sum. ovf = (a[MSB] == b[MSB]) && (r[MSB] != a[MSB]).
- 1 SUB: r = a − b. carry = borrow (1 iff a < b unsigned). ovf = (a[MSB] != b[MSB]) && (r[MSB] != a[MSB]).
- 2 AND: r = a & b.
- 3 OR: r = a | b.
- 4 XOR: r = a ^ b.
- 5 NOT: r = ~a; b is ignored.
- 6 SHL: r = a << 1, zero fill. carry = a[MSB].
- 7 SHR: r = a >> 1, logical, zero fill. carry = a[0].

Flag rules:
- carry = 0 and ovf = 0 for opcodes 2–5.
- ovf = 0 for opcodes 6–7.
- zero and neg are always derived from r.
- An X/undefined `in_op` must not corrupt state. Implement with a full case plus default (default behaves as ADD).

## Timing
- Reset (`rst_n` low, asynchronous): `out_r` = 0, `out_valid` = 0, `out_zero` = 1, `out_neg` = `out_carry` = `out_ovf` = 0. These values hold until the first edge after release.
- Latency: exactly 1 cycle. Inputs sampled at rising edge N with `in_valid` = 1 appear on all outputs after edge N.
- `in_valid` = 0 at an edge: result and flags hold their previous values; `out_valid` goes 0.
- Back-to-back: a new operation may be issued every cycle. Throughput is 1 per clock with no stalls or handshake back-pressure.
- Reset asserted mid-stream: outputs go to reset values immediately. The in-flight result is discarded.
- Combinational path from inputs to output registers only; no input-to-output combinational path.

## Structure
- Shared package `alu_pkg` contains:
  - The opcode enum: `OP_ADD`=0, `OP_SUB`=1, `OP_AND`=2, `OP_OR`=3, `OP_XOR`=4, `OP_NOT`=5, `OP_SHL`=6, `OP_SHR`=7.
  - A flags struct (zero, neg, carry, ovf).
- One natural sub-module, `alu_core`: purely combinational op decode, result and flag computation.
- The top level holds only the output/valid registers and reset logic.

## Test plan
All cases use a = 0x79, b = 0x65, `in_valid` = 1, checked one cycle after issue.
- op 0 ADD → r = 0xDE, carry 0, ovf 1, neg 1, zero 0.
- op 1 SUB → r = 0x14, carry 0. Then a = 0x65, b = 0x79 → r = 0xEC, carry 1, neg 1.
- ops 2/3/4/5 → r = 0x61 / 0x7D / 0x1C / 0x86; carry = ovf = 0.
- op 6 SHL → r = 0xF2, carry 0. op 7 SHR → r = 0x3C, carry 1.
- Edge values:
  - a = 0xFF, b = 0x01, ADD → r = 0x00, zero 1, carry 1, ovf 0.
  - a = 0x80, b = 0x01, SUB → r = 0x7F, ovf 1.
- Control:
  - Hold `in_valid` = 0 → `out_r` unchanged, `out_valid` = 0.
  - Assert `rst_n` = 0 between clock edges → outputs reset immediately.
  - Issue ops 0..7 on consecutive cycles → correct results with no bubbles.
